// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the two-port data-memory arbiter.
// The owner encoding is shared by the arbiter top and its grant-pick sub-module.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    P0   = 2'd1,
    P1   = 2'd2
  } owner_t;

  localparam int DEFAULT_MAX_BURST = 4;

  // The burst counter must be wide enough to hold MAX_BURST itself.
  function automatic int bcnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational grant decision: a lone requester always wins, the
// requester not served last wins a fresh tie, and a running owner is
// preempted only after MAX_BURST consecutive grants.
module dmem_arb_pick
  import dmem_arb_pkg::*;
#(
  parameter int MAX_BURST = DEFAULT_MAX_BURST,
  parameter int BW        = bcnt_width(DEFAULT_MAX_BURST)
) (
  input  logic          req0,
  input  logic          req1,
  input  owner_t        owner,
  input  logic [BW-1:0] bcnt,
  input  owner_t        last,
  output logic          pick0,
  output logic          pick1
);

  localparam logic [BW-1:0] MAX_B = BW'(MAX_BURST);

  always_comb begin
    pick0 = 1'b0;
    pick1 = 1'b0;
    if (req0 && !req1) begin
      pick0 = 1'b1;
    end else if (req1 && !req0) begin
      pick1 = 1'b1;
    end else if (req0 && req1) begin
      case (owner)
        P0: begin
          if (bcnt < MAX_B) pick0 = 1'b1;
          else              pick1 = 1'b1;
        end
        P1: begin
          if (bcnt < MAX_B) pick1 = 1'b1;
          else              pick0 = 1'b1;
        end
        default: begin
          if (last == P0) pick1 = 1'b1;
          else            pick0 = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter with burst-limited fairness,
// registered read return per requester and a saturating stall counter.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_BURST = DEFAULT_MAX_BURST,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic [31:0]      addr0,
  input  logic [31:0]      addr1,
  input  logic [31:0]      wdata0,
  input  logic [31:0]      wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [31:0]      rdata0,
  output logic [31:0]      rdata1,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int BW = bcnt_width(MAX_BURST);
  localparam logic [BW-1:0] MAX_B = BW'(MAX_BURST);

  owner_t        owner_q, owner_n;
  owner_t        last_q, last_n;
  logic [BW-1:0] bcnt_q, bcnt_n;
  logic          pick0, pick1;
  logic [BW-1:0] bcnt_inc;

  dmem_arb_pick #(
    .MAX_BURST(MAX_BURST),
    .BW       (BW)
  ) u_pick (
    .req0 (req0),
    .req1 (req1),
    .owner(owner_q),
    .bcnt (bcnt_q),
    .last (last_q),
    .pick0(pick0),
    .pick1(pick1)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q <= NONE;
      bcnt_q  <= '0;
      last_q  <= P1;
    end else begin
      owner_q <= owner_n;
      bcnt_q  <= bcnt_n;
      last_q  <= last_n;
    end
  end

  assign bcnt_inc = (bcnt_q == MAX_B) ? bcnt_q : bcnt_q + 1'b1;

  always_comb begin
    owner_n = owner_q;
    bcnt_n  = bcnt_q;
    last_n  = last_q;
    if (gnt0) begin
      owner_n = P0;
      bcnt_n  = (owner_q == P0) ? bcnt_inc : BW'(1);
      last_n  = P0;
    end else if (gnt1) begin
      owner_n = P1;
      bcnt_n  = (owner_q == P1) ? bcnt_inc : BW'(1);
      last_n  = P1;
    end else begin
      owner_n = NONE;
      bcnt_n  = '0;
    end
  end

  // Reset gates the grants so nothing reaches memory while rst is low.
  always_comb begin
    gnt0      = rst & pick0;
    gnt1      = rst & pick1;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt1) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      if (gnt0 && !we0) rdata0 <= mem_rdata;
      if (gnt1 && !we1) rdata1 <= mem_rdata;
    end
  end

  // Both requesting always leaves exactly one of them waiting.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (req0 && req1 && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios then random traffic,
// checked against a queue-based reference model and a small behavioural memory.
module tb_dmem_arbiter;

  localparam int MAX_BURST = 4;
  localparam int CNT_W     = 6;
  localparam int STALL_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0]      addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic             gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [31:0]      rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
  logic [CNT_W-1:0] stall_cnt;

  logic [31:0] mem [16];
  logic        mem_load = 1'b1;
  int          cyc = 0;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rd_t;

  rd_t         q0[$];
  rd_t         q1[$];
  logic [31:0] ref_mem [16];
  logic [31:0] last_rd0 = '0, last_rd1 = '0;
  int          holder = -1, run = 0, prev = 1, exp_stall = 0;
  int          num_checks = 0, num_fail = 0;

  dmem_arbiter #(.MAX_BURST(MAX_BURST), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] initWord(input int i);
    return 32'hA500_0000 ^ (i * 32'h0001_0203);
  endfunction

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 16; i++) mem[i] <= initWord(i);
    end else if (mem_we) begin
      mem[mem_addr[5:2]] <= mem_wdata;
    end
  end

  assign mem_rdata = mem[mem_addr[5:2]];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference rules: lone requester wins; fresh tie goes to whoever was not
  // served last; a holder keeps the port for at most MAX_BURST tied grants.
  function automatic int expectedGrant(input bit r0, input bit r1);
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
    if (!r0 && !r1) return -1;
    if (holder < 0) return 1 - prev;
    if (run < MAX_BURST) return holder;
    return 1 - holder;
  endfunction

  task automatic applyStimulus(input bit rs,
                               input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                               input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1,
                               output int g);
    bit          ew;
    logic [31:0] ea, ed;
    @(posedge clk);
    #1;
    rst = rs; req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    #1;
    g  = rs ? expectedGrant(r0, r1) : -1;
    ew = 1'b0; ea = '0; ed = '0;
    if (g == 0) begin ew = w0; ea = a0; ed = d0; end
    if (g == 1) begin ew = w1; ea = a1; ed = d1; end
    checkOutput("gnt0", {31'd0, gnt0}, {31'd0, g == 0});
    checkOutput("gnt1", {31'd0, gnt1}, {31'd0, g == 1});
    checkOutput("mem_we", {31'd0, mem_we}, {31'd0, ew});
    checkOutput("mem_addr", mem_addr, ea);
    checkOutput("mem_wdata", mem_wdata, ed);
    if (rs) checkOutput("stall_cnt", 32'(stall_cnt), exp_stall);
    if (!rs) begin
      holder = -1; run = 0; prev = 1; exp_stall = 0;
      q0.delete(); q1.delete();
      last_rd0 = '0; last_rd1 = '0;
    end else begin
      if (g >= 0) begin
        if (!ew) begin
          if (g == 0) q0.push_back('{ref_mem[ea[5:2]], cyc + 1});
          else        q1.push_back('{ref_mem[ea[5:2]], cyc + 1});
        end else begin
          ref_mem[ea[5:2]] = ed;
        end
        run    = (holder == g) ? ((run < MAX_BURST) ? run + 1 : run) : 1;
        holder = g;
        prev   = g;
      end else begin
        holder = -1;
        run    = 0;
      end
      if (r0 && r1 && exp_stall < STALL_MAX) exp_stall++;
    end
  endtask

  // Read-return monitor: pops the scoreboard whenever a port presents data.
  always @(negedge clk) begin
    rd_t e;
    if (rst) begin
      if (rvalid0) begin
        if (q0.size() == 0) begin
          checkOutput("rvalid0_spurious", {31'd0, rvalid0}, 32'd0);
        end else begin
          e = q0.pop_front();
          checkOutput("rdata0", rdata0, e.data);
          checkOutput("rvalid0_cycle", cyc, e.due);
          last_rd0 = e.data;
        end
      end else begin
        checkOutput("rdata0_hold", rdata0, last_rd0);
        if (q0.size() > 0 && q0[0].due <= cyc) begin
          void'(q0.pop_front());
          checkOutput("rvalid0_missing", {31'd0, rvalid0}, 32'd1);
        end
      end
      if (rvalid1) begin
        if (q1.size() == 0) begin
          checkOutput("rvalid1_spurious", {31'd0, rvalid1}, 32'd0);
        end else begin
          e = q1.pop_front();
          checkOutput("rdata1", rdata1, e.data);
          checkOutput("rvalid1_cycle", cyc, e.due);
          last_rd1 = e.data;
        end
      end else begin
        checkOutput("rdata1_hold", rdata1, last_rd1);
        if (q1.size() > 0 && q1[0].due <= cyc) begin
          void'(q1.pop_front());
          checkOutput("rvalid1_missing", {31'd0, rvalid1}, 32'd1);
        end
      end
    end
  end

  initial begin
    int          g;
    bit          p0, p1, pw0, pw1;
    logic [31:0] pa0, pa1, pd0, pd1;
    for (int i = 0; i < 16; i++) ref_mem[i] = initWord(i);

    applyStimulus(0, 1, 0, 32'h0, 32'h0, 1, 0, 32'h4, 32'h0, g);
    applyStimulus(0, 1, 0, 32'h0, 32'h0, 1, 0, 32'h4, 32'h0, g);
    mem_load = 1'b0;

    // Tie after reset goes to P0, then P1 once P0 drops.
    applyStimulus(1, 1, 0, 32'h0, 32'h0, 1, 0, 32'h4, 32'h0, g);
    applyStimulus(1, 0, 0, 32'h0, 32'h0, 1, 0, 32'h4, 32'h0, g);
    applyStimulus(1, 1, 1, 32'h0, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0, g);
    applyStimulus(1, 0, 0, 32'h0, 32'h0, 1, 0, 32'h0, 32'h0, g);
    applyStimulus(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, g);
    checkOutput("rdata1_deadbeef", rdata1, 32'hDEADBEEF);

    // Continuous tie: 4/4 burst alternation, stall count tracks each cycle.
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, g);
    for (int i = 0; i < 9; i++)
      applyStimulus(1, 1, 0, 32'(4 * i), 32'h0, 1, 0, 32'(4 * i + 4), 32'h0, g);
    applyStimulus(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, g);
    checkOutput("stall_after_9", 32'(stall_cnt), 32'd9);

    applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, g);
    for (int i = 0; i < 10; i++)
      applyStimulus(1, 0, 0, 32'h0, 32'h0, 1, 0, 32'h8, 32'h0, g);
    applyStimulus(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, g);

    // Reset lands while a granted read is returning.
    applyStimulus(1, 1, 0, 32'hC, 32'h0, 0, 0, 32'h0, 32'h0, g);
    applyStimulus(0, 1, 0, 32'hC, 32'h0, 1, 0, 32'h10, 32'h0, g);
    applyStimulus(1, 1, 0, 32'hC, 32'h0, 1, 0, 32'h10, 32'h0, g);
    checkOutput("rvalid0_after_reset", {31'd0, rvalid0}, 32'd0);

    for (int i = 0; i < 70; i++)
      applyStimulus(1, 1, 0, 32'h14, 32'h0, 1, 0, 32'h18, 32'h0, g);
    checkOutput("stall_saturated", 32'(stall_cnt), 32'(STALL_MAX));

    p0 = 0; p1 = 0; pw0 = 0; pw1 = 0; pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
    for (int i = 0; i < 400; i++) begin
      if (!p0 && $urandom_range(0, 9) < 6) begin
        p0 = 1; pw0 = $urandom_range(0, 2) == 0;
        pa0 = {26'd0, 4'($urandom_range(0, 15)), 2'b00}; pd0 = $urandom;
      end
      if (!p1 && $urandom_range(0, 9) < 6) begin
        p1 = 1; pw1 = $urandom_range(0, 2) == 0;
        pa1 = {26'd0, 4'($urandom_range(0, 15)), 2'b00}; pd1 = $urandom;
      end
      applyStimulus($urandom_range(0, 39) != 0, p0, pw0, pa0, pd0, p1, pw1, pa1, pd1, g);
      if (g == 0) p0 = 0;
      if (g == 1) p1 = 0;
    end

    applyStimulus(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, g);
    applyStimulus(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, g);
    @(posedge clk);
    #2;
    checkOutput("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 4, SHALL be the maximum consecutive grants to one requester while the other waits.
REQ-002 Parameter CNT_W, default 16, SHALL be the width of the stall counter.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-low.
REQ-005 Ports req0/req1, input, 1: per-requester access request, held until granted.
REQ-006 Ports we0/we1, input, 1: write (1) or read (0) qualifier for reqN.
REQ-007 Ports addr0/addr1, input, 32: byte address for reqN.
REQ-008 Ports wdata0/wdata1, input, 32: write data for reqN.
REQ-009 Ports gnt0/gnt1, output, 1: access accepted this cycle; combinational from state and requests.
REQ-010 Ports rvalid0/rvalid1, output, 1: read data valid for requester N, registered.
REQ-011 Ports rdata0/rdata1, output, 32: read data for requester N, registered.
REQ-012 Port mem_we, output, 1: write enable to the data memory.
REQ-013 Port mem_addr, output, 32: address to the data memory.
REQ-014 Port mem_wdata, output, 32: write data to the data memory.
REQ-015 Port mem_rdata, input, 32: combinational read data from the data memory.
REQ-016 Port stall_cnt, output, CNT_W: saturating count of cycles in which a request was not granted.

Function
REQ-017 At most one of gnt0/gnt1 SHALL be high in any cycle.
REQ-018 A grant SHALL be issued only to a requester whose req is high.
REQ-019 Whenever any req is high and rst is high, exactly one grant SHALL be issued.
REQ-020 State SHALL be owner in {NONE, P0, P1}, burst counter bcnt (saturating at MAX_BURST) and last-served pointer last.
REQ-021 Only one requester active: it SHALL be granted.
REQ-022 Both active with owner NONE: the requester not equal to last SHALL be granted.
REQ-023 Both active with owner=k: k SHALL be granted while bcnt<MAX_BURST; once bcnt=MAX_BURST, the other SHALL be granted.
REQ-024 On a grant to k: owner<=k; bcnt<=bcnt+1 (saturating) if owner was k, else bcnt<=1; last<=k.
REQ-025 On a cycle with no grant: owner<=NONE and bcnt<=0; last SHALL be held.
REQ-026 Granted requester k SHALL drive mem_addr=addrk, mem_wdata=wdatak and mem_we=wek in the same cycle.
REQ-027 With no grant, mem_we, mem_addr and mem_wdata SHALL be 0.
REQ-028 Read latency: a read granted in cycle t SHALL capture mem_rdata into rdatak at the end of t, with rvalidk=1 for exactly cycle t+1.
REQ-029 rdataN SHALL hold its last value when no new read completes.
REQ-030 A granted write SHALL not assert rvalid.
REQ-031 Back-to-back reads SHALL give rvalid on consecutive cycles with no bubble.
REQ-032 stall_cnt SHALL increment by 1 per cycle in which both req are high (one ungranted) and SHALL saturate at all-ones.

Reset
REQ-033 While rst=0 at a rising edge: owner<=NONE, bcnt<=0, last<=P1 (P0 wins the first tie), rvalid0/1<=0, rdata0/1<=0, stall_cnt<=0.
REQ-034 While rst=0, gnt0, gnt1 and mem_we SHALL be forced to 0 combinationally.
REQ-035 Reset asserted mid-burst or with a read in flight SHALL drop that read: no rvalid in the cycle after reset.

Structure
REQ-036 Package dmem_arb_pkg SHALL hold the owner enum (NONE/P0/P1) and the default MAX_BURST constant.
REQ-037 The grant decision (REQ-021..023) SHALL be a combinational sub-module dmem_arb_pick; state registers and datapath muxing SHALL remain in dmem_arbiter.

Verification
REQ-038 After reset, both req high, reads at 0x0 and 0x4 -> gnt0 first, rdata0=mem[0] with rvalid0 next cycle; then gnt1 once req0 drops.
REQ-039 req0 writes 0xDEADBEEF to 0x0 -> mem_we=1 and mem_addr=0x0 same cycle, no rvalid0; req1 read of 0x0 afterwards -> rdata1=0xDEADBEEF.
REQ-040 Both hold req high continuously, MAX_BURST=4 -> grant pattern 0,0,0,0,1,1,1,1,0 and stall_cnt=9 after 9 cycles.
REQ-041 Only req1 high for 10 cycles -> gnt1 every cycle (bcnt saturates, no switch) and stall_cnt=0.
REQ-042 rst low during the cycle after a granted read -> rvalid stays 0, gnt0/gnt1/mem_we=0, stall_cnt=0; next tie -> P0 granted.
REQ-043 Force stall_cnt to all-ones with both req high -> stall_cnt holds all-ones.
